// File: rtl/plic_hart_claim_ctrl_if.sv
// Bus, arbiter and kid-side signals of one PLIC hart claim controller.
// The slave modport is the controller's view; master is the surrounding logic.
interface plic_hart_claim_ctrl_if #(
  parameter int PRIO_BIT = 5,
  parameter int ID_NUM   = 10
);
  logic                bus_hreg_claim_rd_req;
  logic                bus_hreg_claim_rd_mmode;
  logic                hreg_bus_claim_rd_ack;
  logic [ID_NUM-1:0]   hreg_bus_claim_rd_data;
  logic                bus_hreg_th_wr;
  logic                bus_hreg_th_wr_mmode;
  logic [PRIO_BIT-1:0] bus_hreg_th_wdata;
  logic                bus_hreg_cmplt_wr;
  logic                kid_hreg_req_chg;
  logic [PRIO_BIT-1:0] hreg_arbx_prio_mth;
  logic [PRIO_BIT-1:0] hreg_arbx_prio_sth;
  logic                hreg_arbx_arb_start;
  logic                arbx_hreg_arb_start_ack;
  logic                hreg_arbx_arb_flush;
  logic                arbx_hreg_claim_reg_ready;
  logic [ID_NUM-1:0]   arbx_hreg_claim_id;
  logic                arbx_hreg_claim_mmode;
  logic                hreg_arbx_mint_claim;
  logic                hreg_arbx_sint_claim;
  logic                hreg_kid_claim_vld;
  logic [ID_NUM-1:0]   hreg_kid_claim_id;

  modport slave (
    input  bus_hreg_claim_rd_req, bus_hreg_claim_rd_mmode,
    input  bus_hreg_th_wr, bus_hreg_th_wr_mmode, bus_hreg_th_wdata,
    input  bus_hreg_cmplt_wr, kid_hreg_req_chg,
    input  arbx_hreg_arb_start_ack, arbx_hreg_claim_reg_ready,
    input  arbx_hreg_claim_id, arbx_hreg_claim_mmode,
    output hreg_bus_claim_rd_ack, hreg_bus_claim_rd_data,
    output hreg_arbx_prio_mth, hreg_arbx_prio_sth,
    output hreg_arbx_arb_start, hreg_arbx_arb_flush,
    output hreg_arbx_mint_claim, hreg_arbx_sint_claim,
    output hreg_kid_claim_vld, hreg_kid_claim_id
  );

  modport master (
    output bus_hreg_claim_rd_req, bus_hreg_claim_rd_mmode,
    output bus_hreg_th_wr, bus_hreg_th_wr_mmode, bus_hreg_th_wdata,
    output bus_hreg_cmplt_wr, kid_hreg_req_chg,
    output arbx_hreg_arb_start_ack, arbx_hreg_claim_reg_ready,
    output arbx_hreg_claim_id, arbx_hreg_claim_mmode,
    input  hreg_bus_claim_rd_ack, hreg_bus_claim_rd_data,
    input  hreg_arbx_prio_mth, hreg_arbx_prio_sth,
    input  hreg_arbx_arb_start, hreg_arbx_arb_flush,
    input  hreg_arbx_mint_claim, hreg_arbx_sint_claim,
    input  hreg_kid_claim_vld, hreg_kid_claim_id
  );
endinterface

// File: rtl/plic_hart_claim_ctrl.sv
// Per-hart PLIC claim controller: runs arbitration rounds, latches the winner,
// serves M/S claim reads and holds the M/S priority thresholds.
module plic_hart_claim_ctrl #(
  parameter int PRIO_BIT = 5,
  parameter int ID_NUM   = 10
) (
  input  logic                   plic_clk,
  input  logic                   plicrst_b,
  plic_hart_claim_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    CLAIM = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [ID_NUM-1:0]   id_q;
  logic                mmode_q;
  logic [PRIO_BIT-1:0] mth_q, sth_q;
  logic                evt, hit, latch, clear;
  logic                arb_start, arb_flush, rd_ack, mint, sint, kid_vld;
  logic [ID_NUM-1:0]   rd_data, kid_id;

  assign evt = bus.bus_hreg_th_wr | bus.bus_hreg_cmplt_wr | bus.kid_hreg_req_chg;

  always_ff @(posedge plic_clk or negedge plicrst_b) begin
    if (!plicrst_b) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge plic_clk or negedge plicrst_b) begin
    if (!plicrst_b) begin
      mth_q <= '0;
      sth_q <= '0;
    end else if (bus.bus_hreg_th_wr) begin
      if (bus.bus_hreg_th_wr_mmode) mth_q <= bus.bus_hreg_th_wdata;
      else                          sth_q <= bus.bus_hreg_th_wdata;
    end
  end

  always_ff @(posedge plic_clk or negedge plicrst_b) begin
    if (!plicrst_b) begin
      id_q    <= '0;
      mmode_q <= 1'b0;
    end else if (latch) begin
      id_q    <= bus.arbx_hreg_claim_id;
      mmode_q <= bus.arbx_hreg_claim_mmode;
    end else if (clear) begin
      id_q    <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    arb_start = 1'b0;
    arb_flush = 1'b0;
    rd_ack    = 1'b0;
    rd_data   = '0;
    mint      = 1'b0;
    sint      = 1'b0;
    kid_vld   = 1'b0;
    kid_id    = '0;
    latch     = 1'b0;
    clear     = 1'b0;
    hit       = (state == CLAIM) && (id_q != '0) &&
                (mmode_q == bus.bus_hreg_claim_rd_mmode);
    case (state)
      IDLE:  state_nxt = START;
      START: begin
        arb_start = 1'b1;
        if (bus.arbx_hreg_arb_start_ack) state_nxt = WAIT;
      end
      // A re-arb event outranks a same-cycle ready: the result may already be stale.
      WAIT: begin
        if (evt) begin
          arb_flush = 1'b1;
          state_nxt = START;
        end else if (bus.arbx_hreg_claim_reg_ready) begin
          latch     = 1'b1;
          state_nxt = VALID;
        end
      end
      VALID: begin
        if (bus.bus_hreg_claim_rd_req) state_nxt = CLAIM;
        else if (evt)                  state_nxt = START;
      end
      CLAIM: begin
        rd_ack    = 1'b1;
        state_nxt = START;
        if (hit) begin
          rd_data = id_q;
          mint    = mmode_q;
          sint    = ~mmode_q;
          kid_vld = 1'b1;
          kid_id  = id_q;
          clear   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.hreg_bus_claim_rd_ack  = rd_ack;
  assign bus.hreg_bus_claim_rd_data = rd_data;
  assign bus.hreg_arbx_prio_mth     = mth_q;
  assign bus.hreg_arbx_prio_sth     = sth_q;
  assign bus.hreg_arbx_arb_start    = arb_start;
  assign bus.hreg_arbx_arb_flush    = arb_flush;
  assign bus.hreg_arbx_mint_claim   = mint;
  assign bus.hreg_arbx_sint_claim   = sint;
  assign bus.hreg_kid_claim_vld     = kid_vld;
  assign bus.hreg_kid_claim_id      = kid_id;

endmodule
